// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment driver: BCD digits plus decimal points are shadowed, swapped in
// atomically at frame boundaries, and scanned onto one segment bus with a dead time per slot.
module seg7_scan_mux #(
   parameter int NUM_DIGITS   = 3,
   parameter int SCAN_DIV     = 4,
   parameter int BLANK_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    lz_blank,
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_done
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

   // Segment pattern a..g for one BCD code; codes 10-15 show a dash.
   function automatic logic [6:0] encode(input logic [3:0] code);
      logic [6:0] pat;
      case (code)
         4'd0:    pat = 7'b1111110;
         4'd1:    pat = 7'b0110000;
         4'd2:    pat = 7'b1101101;
         4'd3:    pat = 7'b1111001;
         4'd4:    pat = 7'b0110011;
         4'd5:    pat = 7'b1011011;
         4'd6:    pat = 7'b1011111;
         4'd7:    pat = 7'b1110000;
         4'd8:    pat = 7'b1111111;
         4'd9:    pat = 7'b1110011;
         default: pat = 7'b0000001;
      endcase
      return pat;
   endfunction

   logic [CW-1:0]           cnt_q, cnt_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*NUM_DIGITS-1:0] active_bcd_q, active_bcd_d;
   logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
   logic                    pending_q, pending_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
   logic                    frame_done_q, frame_done_d;

   logic                    cnt_wrap_s;
   logic                    boundary_s;
   logic [NUM_DIGITS-1:0]   lz_mask_s;
   logic [NUM_DIGITS-1:0]   sel_s;
   logic                    all_zero_s;
   logic [3:0]              cur_bcd_s;
   logic                    cur_dp_s;
   logic                    cur_lz_s;

   // Scan counters, shadow/active transfer and frame boundary detection.
   always_comb begin
      cnt_wrap_s   = (cnt_q == LAST_CNT);
      boundary_s   = cnt_wrap_s && (idx_q == LAST_IDX);
      cnt_d        = cnt_wrap_s ? '0 : cnt_q + 1'b1;
      idx_d        = idx_q;
      shadow_bcd_d = shadow_bcd_q;
      shadow_dp_d  = shadow_dp_q;
      active_bcd_d = active_bcd_q;
      active_dp_d  = active_dp_q;
      pending_d    = pending_q;
      frame_done_d = boundary_s;

      if (cnt_wrap_s) begin
         if (idx_q == LAST_IDX) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end else begin
         idx_d = idx_q;
      end

      if (load) begin
         shadow_bcd_d = bcd_in;
         shadow_dp_d  = dp_in;
      end else begin
         shadow_bcd_d = shadow_bcd_q;
         shadow_dp_d  = shadow_dp_q;
      end

      // A load on the boundary edge bypasses the shadow so it shows in the frame starting now.
      if (boundary_s) begin
         pending_d = 1'b0;
         if (load) begin
            active_bcd_d = bcd_in;
            active_dp_d  = dp_in;
         end else if (pending_q) begin
            active_bcd_d = shadow_bcd_q;
            active_dp_d  = shadow_dp_q;
         end else begin
            active_bcd_d = active_bcd_q;
            active_dp_d  = active_dp_q;
         end
      end else if (load) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
   end

   // Leading-zero mask: digit k blanks when it and all more-significant digits are zero.
   always_comb begin
      all_zero_s = 1'b1;
      lz_mask_s  = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero_s   = all_zero_s && (active_bcd_q[4*i +: 4] == 4'd0);
         lz_mask_s[i] = lz_blank && all_zero_s && (i != 0);
      end
   end

   // Select the digit under scan and build the next segment/enable values.
   always_comb begin
      sel_s     = '0;
      cur_bcd_s = 4'd0;
      cur_dp_s  = 1'b0;
      cur_lz_s  = 1'b0;
      seg_d     = 8'h00;
      dig_en_d  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            sel_s[i]  = 1'b1;
            cur_bcd_s = active_bcd_q[4*i +: 4];
            cur_dp_s  = active_dp_q[i];
            cur_lz_s  = lz_mask_s[i];
         end else begin
            sel_s[i] = 1'b0;
         end
      end
      if (cnt_q < BLANK_END) begin
         seg_d    = 8'h00;
         dig_en_d = '0;
      end else if (cur_lz_s) begin
         seg_d    = {7'b0000000, cur_dp_s};
         dig_en_d = sel_s;
      end else begin
         seg_d    = {encode(cur_bcd_s), cur_dp_s};
         dig_en_d = sel_s;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_bcd_q <= '0;
         shadow_dp_q  <= '0;
         active_bcd_q <= '0;
         active_dp_q  <= '0;
         pending_q    <= 1'b0;
         seg_q        <= 8'h00;
         dig_en_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_bcd_q <= shadow_bcd_d;
         shadow_dp_q  <= shadow_dp_d;
         active_bcd_q <= active_bcd_d;
         active_dp_q  <= active_dp_d;
         pending_q    <= pending_d;
         seg_q        <= seg_d;
         dig_en_q     <= dig_en_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign seg        = seg_q;
   assign dig_en     = dig_en_q;
   assign frame_done = frame_done_q;

endmodule
